// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: address map constants, bus widths and the
// sprite-DMA state encoding used by oam_dma.
package nes_bus_pkg;

    localparam int BUS_W  = 16;
    localparam int DATA_W = 8;

    localparam logic [BUS_W-1:0] DMA_REG_ADDR_C  = 16'h4014;
    localparam logic [BUS_W-1:0] OAM_DATA_ADDR_C = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and memory-bus-side signals of the sprite-DMA arbiter.
// master: the oam_dma block (owns the shared bus); slave: the CPU/memory side.
interface oam_dma_if;
    import nes_bus_pkg::*;

    logic [BUS_W-1:0]  cpu_addr;
    logic [DATA_W-1:0] cpu_d_out;
    logic              cpu_write;
    logic [DATA_W-1:0] bus_d_in;
    logic              cpu_ready;
    logic [BUS_W-1:0]  bus_addr;
    logic [DATA_W-1:0] bus_d_out;
    logic              bus_write;
    logic              dma_active;

    modport master (
        input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
        output cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
    );

    modport slave (
        output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
        input  cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
    );

endinterface

// File: rtl/oam_dma.sv
// Sprite-DMA controller and CPU bus arbiter: copies one page to the OAM data port.
// Define OAM_DMA_ALIGN_EN to insert the ALIGN cycle that starts reads on an even bus cycle.
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [BUS_W-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
    parameter logic [BUS_W-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C,
    parameter int               XFER_LEN      = 256
) (
    input  logic      clk,
    input  logic      reset,
    oam_dma_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t        state;
    dma_state_t        next_state;
    logic [7:0]        page;
    logic [7:0]        idx;
    logic [DATA_W-1:0] data_q;
    logic              cpu_ready_q;
    logic              dma_active_q;
    logic              trigger;

    assign trigger = bus.cpu_write && (bus.cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic cyc_par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_par <= 1'b0;
        else        cyc_par <= ~cyc_par;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cpu_ready_q  <= 1'b1;
            dma_active_q <= 1'b0;
            page         <= '0;
            idx          <= '0;
            data_q       <= '0;
        end else begin
            state        <= next_state;
            cpu_ready_q  <= (next_state == IDLE);
            dma_active_q <= (next_state == ALIGN) || (next_state == READ) || (next_state == WRITE);
            if (state == IDLE && trigger) begin
                page <= bus.cpu_d_out;
                idx  <= '0;
            end
            if (state == READ)  data_q <= bus.bus_d_in;
            if (state == WRITE) idx    <= idx + 8'd1;
        end
    end

    // NOTE: defaulting every always_comb output up front prevents inferred latches.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (trigger) next_state = HALT;
            // A CPU write burst finishes before the bus is taken.
            HALT: if (!bus.cpu_write) begin
`ifdef OAM_DMA_ALIGN_EN
                next_state = cyc_par ? READ : ALIGN;
`else
                next_state = READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN:   next_state = READ;
`endif
            READ:    next_state = WRITE;
            WRITE:   next_state = (idx == LAST_IDX) ? IDLE : READ;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_addr  = bus.cpu_addr;
        bus.bus_d_out = bus.cpu_d_out;
        bus.bus_write = bus.cpu_write;
        case (state)
            ALIGN: bus.bus_write = 1'b0;
            READ: begin
                bus.bus_addr  = {page, idx};
                bus.bus_write = 1'b0;
            end
            WRITE: begin
                bus.bus_addr  = OAM_DATA_ADDR;
                bus.bus_d_out = data_q;
                bus.bus_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: IDLE passthrough vectors, page transfers
// scored against a memory model, HALT stretch, page wrap and mid-transfer reset.
module tb_oam_dma;
    import nes_bus_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  d;
        logic        we;
        logic [15:0] e_addr;
        logic [7:0]  e_d;
        logic        e_we;
        logic        e_rdy;
        logic        e_act;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic tb_par;
    int   n_vec = 0;
    int   n_bad = 0;
    wr_t  sb[$];

    oam_dma_if dif ();

    oam_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    assign dif.bus_d_in = mem_byte(dif.bus_addr);

    // Reference bus-cycle parity: 0 out of reset, toggles every cycle after.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
        dif.cpu_addr  = a;
        dif.cpu_d_out = d;
        dif.cpu_write = we;
    endtask

    task automatic run_dma(input logic [7:0] pg, input int extra, input logic want_par,
                           input int abort_at);
        int         l_cnt = 0;
        int         h_cnt = 0;
        int         a_cnt = 0;
        int         rd_cnt = 0;
        int         wr_cnt = 0;
        int         viol = 0;
        logic       done = 1'b0;
        logic       par0;
        logic       exp_align;
        logic [7:0] rd_idx = 8'h00;
        wr_t        got;
        wr_t        exp;

        @(posedge clk); #1;
        if (tb_par != want_par) begin
            @(posedge clk); #1;
        end
        par0 = tb_par;
        drive(16'h4014, pg, 1'b1);
        for (int i = 0; i < 256; i++) begin
            exp.addr = 16'h2004;
            exp.data = mem_byte({pg, 8'(i)});
            sb.push_back(exp);
        end
`ifdef OAM_DMA_ALIGN_EN
        exp_align = par0 ^ extra[0];
`else
        exp_align = 1'b0;
`endif
        @(negedge clk);
        check("trig_on_bus", {dif.bus_addr, 7'b0, dif.bus_write}, {16'h4014, 8'h01});
        check("trig_ready", dif.cpu_ready, 1'b1);

        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk); #1;
            if (cyc < extra) drive(16'h4014, 8'h55, 1'b1);
            else             drive(16'h1234, 8'h00, 1'b0);
            @(negedge clk);
            if (dif.cpu_ready) begin
                done = 1'b1;
                break;
            end
            l_cnt++;
            if (!dif.dma_active) begin
                h_cnt++;
                if (dif.bus_addr != dif.cpu_addr || dif.bus_write != dif.cpu_write) viol++;
            end else if (dif.bus_write) begin
                wr_cnt++;
                got.addr = dif.bus_addr;
                got.data = dif.bus_d_out;
                if (sb.size() == 0) begin
                    check("oam_wr_extra", got, '0);
                end else begin
                    exp = sb.pop_front();
                    check("oam_wr", got, exp);
                end
                if (wr_cnt == abort_at) begin
                    #2 reset = 1'b0;
                    #1;
                    check("abort_ready", dif.cpu_ready, 1'b1);
                    check("abort_active", dif.dma_active, 1'b0);
                    check("abort_pass", {dif.bus_addr, 7'b0, dif.bus_write}, {16'h1234, 8'h00});
                    sb.delete();
                    @(negedge clk);
                    reset = 1'b1;
                    viol = 0;
                    for (int i = 0; i < 600; i++) begin
                        @(negedge clk);
                        if (dif.dma_active || dif.bus_write || !dif.cpu_ready ||
                            dif.bus_addr != 16'h1234) viol++;
                    end
                    check("abort_quiet", viol, 0);
                    return;
                end
            end else if (rd_cnt == 0 && a_cnt == 0 && dif.bus_addr == dif.cpu_addr) begin
                a_cnt++;
            end else begin
`ifdef OAM_DMA_ALIGN_EN
                if (rd_cnt == 0) check("first_rd_par", tb_par, 1'b0);
`endif
                check("rd_addr", dif.bus_addr, {pg, rd_idx});
                rd_idx++;
                rd_cnt++;
            end
        end

        check("done", done, 1'b1);
        check("halt_len", l_cnt, 513 + extra + int'(exp_align));
        check("halt_cycles", h_cnt, 1 + extra);
        check("align_cycles", a_cnt, int'(exp_align));
        check("reads", rd_cnt, 256);
        check("writes", wr_cnt, 256);
        check("sb_left", sb.size(), 0);
        check("halt_pass", viol, 0);
        check("end_active", dif.dma_active, 1'b0);
        check("end_pass", dif.bus_addr, 16'h1234);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h8000, 8'h00, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h0300, 8'hA5, 1'b1, 16'h0300, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h4015, 8'h02, 1'b1, 16'h4015, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h4013, 8'h02, 1'b1, 16'h4013, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h4014, 8'h02, 1'b0, 16'h4014, 8'h02, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h2004, 8'h3C, 1'b1, 16'h2004, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 8'hFF, 1'b0, 16'hFFFF, 8'hFF, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        drive(16'h8000, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", dif.cpu_ready, 1'b1);
        check("rst_active", dif.dma_active, 1'b0);
        check("rst_addr", dif.bus_addr, 16'h8000);
        check("rst_write", dif.bus_write, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].addr, vecs[i].d, vecs[i].we);
            @(negedge clk);
            check("vec_addr", dif.bus_addr, vecs[i].e_addr);
            check("vec_dout", dif.bus_d_out, vecs[i].e_d);
            check("vec_write", dif.bus_write, vecs[i].e_we);
            check("vec_ready", dif.cpu_ready, vecs[i].e_rdy);
            check("vec_active", dif.dma_active, vecs[i].e_act);
        end

        run_dma(8'h02, 0, 1'b0, 0);
        run_dma(8'h02, 0, 1'b1, 0);
        run_dma(8'h07, 2, 1'b0, 0);
        run_dma(8'h07, 2, 1'b1, 0);
        run_dma(8'hFF, 0, 1'b1, 0);
        run_dma(8'h02, 0, 1'b0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
